rsp_skid_buffer: RTL and testbench
==================================

RSP_SKID_BUFFER -- requirements
Module: rsp_skid_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the payload width of m_rsp_data and src_data.
REQ-002 Parameter CNT_WIDTH, default 16, sets the width of stall_cnt (present only with RSP_SKID_PERF_EN).
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port flush  input  1  synchronous discard of all buffered entries.
REQ-006 Port m_rsp_vld  input  1  upstream response valid.
REQ-007 Port m_rsp_rdy  output  1  upstream ready, driven directly from a flop.
REQ-008 Port m_rsp_data  input  DATA_WIDTH  upstream response payload.
REQ-009 Port src_vld  output  1  downstream valid, driven from state.
REQ-010 Port src_rdy  input  1  downstream ready.
REQ-011 Port src_data  output  DATA_WIDTH  downstream payload, driven directly from the main register.
REQ-012 Port occ  output  2  current entry count, 0..2.
REQ-013 Port stall_cnt  output  CNT_WIDTH  downstream stall cycle count (RSP_SKID_PERF_EN only).

Function
REQ-014 Upstream transfer (IN) = m_rsp_vld && m_rsp_rdy; downstream transfer (OUT) = src_vld && src_rdy; both sampled at the same rising edge.
REQ-015 Storage: a main register and a skid register, each DATA_WIDTH bits; capacity is 2 entries.
REQ-016 State machine with states EMPTY (occ=0), BUSY (occ=1, main valid) and FULL (occ=2, main and skid valid).
REQ-017 EMPTY: on IN -> BUSY with main <= m_rsp_data; otherwise stay in EMPTY.
REQ-018 BUSY: IN && OUT -> stay in BUSY with main <= m_rsp_data; IN && !OUT -> FULL with skid <= m_rsp_data; !IN && OUT -> EMPTY; neither -> stay in BUSY.
REQ-019 FULL: on OUT -> BUSY with main <= skid; otherwise stay in FULL; IN is impossible because m_rsp_rdy=0.
REQ-020 m_rsp_rdy is registered: it equals 1 in the cycle after any edge whose next state is not FULL, and 0 otherwise, so upstream sees no combinational path from src_rdy.
REQ-021 src_vld=1 exactly when the state is not EMPTY; src_data=main at all times, including stale contents when src_vld=0.
REQ-022 Latency: data accepted at edge N is presented on src_data after edge N when the buffer was EMPTY, and ordering is strictly FIFO.
REQ-023 src_data and src_vld, once asserted, stay stable until OUT occurs or flush is applied; no entry is dropped or duplicated.
REQ-024 Sustained src_rdy=1 with m_rsp_vld=1 gives 1 transfer per cycle with no bubbles.
REQ-025 flush=1 at an edge forces EMPTY, sets m_rsp_rdy to 1, and ignores any simultaneous IN and OUT; data registers are not cleared.
REQ-026 occ is driven from state: EMPTY=0, BUSY=1, FULL=2; the value 3 shall never occur.

Reset
REQ-027 rst_n=0 asynchronously forces: state EMPTY, occ=0, src_vld=0, m_rsp_rdy=0, and stall_cnt=0 when present.
REQ-028 The first rising edge with rst_n=1 sets m_rsp_rdy=1; no IN is possible before that edge.
REQ-029 Main and skid registers are reset to 0, so src_data=0 after reset.
REQ-030 Reset asserted mid-operation discards all entries, with no partial transfer visible afterwards.

Configuration
REQ-031 Macro RSP_SKID_PERF_EN defined: stall_cnt exists and increments by 1 on each edge where src_vld=1 && src_rdy=0.
REQ-032 With RSP_SKID_PERF_EN, stall_cnt saturates at all-ones and is cleared by reset only, not by flush.
REQ-033 RSP_SKID_PERF_EN undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-034 Reset, then stream 0xA0..0xA7 with src_rdy=1 held -> src_data shows 0xA0..0xA7 on consecutive cycles, m_rsp_rdy stays 1, occ stays 1.
REQ-035 BUSY holding 0x11, src_rdy=0, push 0x22 -> occ=2, m_rsp_rdy=0 next cycle; release src_rdy -> output 0x11 then 0x22, then occ=0.
REQ-036 FULL, then flush=1 with src_rdy=1 -> occ=0, src_vld=0 and m_rsp_rdy=1 next cycle; neither 0x11 nor 0x22 is output.
REQ-037 Random m_rsp_vld/src_rdy over 10000 cycles, DATA_WIDTH=8 -> scoreboard order exact, src_data stable during stalls, occ never 3.
REQ-038 Assert rst_n=0 mid-cycle while FULL -> outputs reach their reset values immediately, without waiting for clk.
REQ-039 RSP_SKID_PERF_EN, CNT_WIDTH=4, src_vld=1 with src_rdy=0 for 20 cycles -> stall_cnt=15, and it remains 15 after flush.

Source files
------------

// File: rtl/rsp_skid_buffer.sv
// rsp_skid_buffer: two-entry registered skid buffer for a response channel.
// Breaks the ready path: m_rsp_rdy comes straight from a flop, so upstream
// never sees a combinational path from src_rdy. Strict FIFO order.
//
// Optional feature macro: RSP_SKID_PERF_EN adds the stall_cnt output, a
// saturating count of edges where src_vld=1 and src_rdy=0.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush        - synchronous discard of all buffered entries
//   m_rsp_vld    - upstream valid
//   m_rsp_rdy    - upstream ready (registered)
//   m_rsp_data   - upstream payload, DATA_WIDTH bits
//   src_vld      - downstream valid (registered)
//   src_rdy      - downstream ready
//   src_data     - downstream payload, taken from the main register
//   occ          - entry count 0..2
//   stall_cnt    - downstream stall count, CNT_WIDTH bits (RSP_SKID_PERF_EN)
module rsp_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  m_rsp_vld,
  output logic                  m_rsp_rdy,
  input  logic [DATA_WIDTH-1:0] m_rsp_data,
  output logic                  src_vld,
  input  logic                  src_rdy,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic [1:0]            occ
`ifdef RSP_SKID_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  // Encoding equals the entry count so occ is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic                  in_xfer;
  logic                  out_xfer;

  assign in_xfer  = m_rsp_vld && m_rsp_rdy;
  assign out_xfer = src_vld && src_rdy;

  // Next-state and datapath selection; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = BUSY;
            main_d  = m_rsp_data;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = m_rsp_data;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = m_rsp_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // m_rsp_rdy is low here, so only the drain case matters.
          if (out_xfer) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, storage and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      m_rsp_rdy <= 1'b0;
      src_vld   <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      m_rsp_rdy <= (state_d != FULL);
      src_vld   <= (state_d != EMPTY);
    end
  end

  assign occ      = state_q;
  assign src_data = main_q;

`ifdef RSP_SKID_PERF_EN
  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (src_vld && !src_rdy && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rsp_skid_buffer.sv
// Scoreboard bench for rsp_skid_buffer: the driver pushes each accepted
// payload into a queue, the negedge monitor pops on every downstream transfer.
module tb_rsp_skid_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          m_rsp_vld;
  logic          m_rsp_rdy;
  logic [DW-1:0] m_rsp_data;
  logic          src_vld;
  logic          src_rdy;
  logic [DW-1:0] src_data;
  logic [1:0]    occ;
`ifdef RSP_SKID_PERF_EN
  logic [CW-1:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb_q[$];
  logic          seen_edge;
  logic          held;
  logic [DW-1:0] held_data;

  rsp_skid_buffer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .m_rsp_vld  (m_rsp_vld),
    .m_rsp_rdy  (m_rsp_rdy),
    .m_rsp_data (m_rsp_data),
    .src_vld    (src_vld),
    .src_rdy    (src_rdy),
    .src_data   (src_data),
    .occ        (occ)
`ifdef RSP_SKID_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Marks that at least one rising edge has happened out of reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_edge <= 1'b0;
    else        seen_edge <= 1'b1;
  end

  // Apply inputs for the coming edge; record the payload if it will be taken.
  task automatic drive(input logic vld, input logic [DW-1:0] data,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    m_rsp_vld  = vld;
    m_rsp_data = data;
    src_rdy    = rdy;
    flush      = fl;
    if (rst_n && vld && m_rsp_rdy && !fl) sb_q.push_back(data);
  endtask

  // Monitor: occupancy model, handshake invariants, ordering and stall stability.
  always @(negedge clk) begin
    int exp_occ;
    logic [DW-1:0] exp_d;
    if (!rst_n) begin
      sb_q.delete();
      held = 1'b0;
    end else begin
      exp_occ = sb_q.size() - ((m_rsp_vld && m_rsp_rdy && !flush) ? 1 : 0);
      chk("occ", 32'(occ), 32'(exp_occ));
      chk("src_vld_vs_occ", 32'(src_vld), 32'(exp_occ != 0));
      if (seen_edge) chk("m_rsp_rdy_vs_occ", 32'(m_rsp_rdy), 32'(exp_occ != 2));
      if (held) begin
        chk("stall_vld", 32'(src_vld), 32'd1);
        chk("stall_data", 32'(src_data), 32'(held_data));
      end
      if (flush) begin
        sb_q.delete();
        held = 1'b0;
      end else begin
        if (src_vld && src_rdy) begin
          chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            exp_d = sb_q.pop_front();
            chk("src_data", 32'(src_data), 32'(exp_d));
          end
        end
        held      = src_vld && !src_rdy;
        held_data = src_data;
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; m_rsp_vld = 1'b0; m_rsp_data = '0; src_rdy = 1'b0;
    held = 1'b0; held_data = '0;
    #1;
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_src_vld", 32'(src_vld), 32'd0);
    chk("rst_m_rsp_rdy", 32'(m_rsp_rdy), 32'd0);
    chk("rst_src_data", 32'(src_data), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_rdy", 32'(m_rsp_rdy), 32'd1);

    // Back-to-back stream with downstream always ready.
    for (int i = 0; i < 8; i++) drive(1'b1, DW'(8'hA0 + i), 1'b1, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Fill to FULL under backpressure, then drain in order.
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("full_occ", 32'(occ), 32'd2);
    chk("full_rdy", 32'(m_rsp_rdy), 32'd0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Fill to FULL, then flush with src_rdy high.
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_occ", 32'(occ), 32'd0);
    chk("flush_vld", 32'(src_vld), 32'd0);
    chk("flush_rdy", 32'(m_rsp_rdy), 32'd1);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 10000; i++)
      drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));

    // Asynchronous reset while FULL.
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(occ), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_occ", 32'(occ), 32'd0);
    chk("async_rst_vld", 32'(src_vld), 32'd0);
    chk("async_rst_rdy", 32'(m_rsp_rdy), 32'd0);
    chk("async_rst_data", 32'(src_data), 32'd0);
`ifdef RSP_SKID_PERF_EN
    chk("async_rst_stall", 32'(stall_cnt), 32'd0);
`endif
    #9 rst_n = 1'b1;

`ifdef RSP_SKID_PERF_EN
    drive(1'b1, 8'h5A, 1'b0, 1'b0);
    repeat (6) drive(1'b0, '0, 1'b0, 1'b0);
    chk("stall_cnt_5", 32'(stall_cnt), 32'd5);
    repeat (20) drive(1'b0, '0, 1'b0, 1'b0);
    chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("stall_cnt_flush", 32'(stall_cnt), 32'd15);
`endif

    // Post-reset transfer and final drain.
    drive(1'b1, 8'h77, 1'b1, 1'b0);
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_occ", 32'(occ), 32'd0);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
